// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RISC-V style datapath.
// Outputs are decoded from the current state; reset gates every control output to 0.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       iord,
   output logic       mem_to_reg,
   output logic       pc_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] ALUOp,
   output logic       retire,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC_R  = 4'd6,
      S_EXEC_I  = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_ILLEGAL = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t cur, nxt;

   always_ff @(posedge clk) begin
      if (reset) cur <= S_FETCH;
      else       cur <= nxt;
   end

   assign state = cur;

   // Next-state logic; encodings 11-15 fall through to FETCH via the default.
   always_comb begin
      nxt = S_FETCH;
      case (cur)
         S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: nxt = S_MEMADR;
               OP_RTYPE:          nxt = S_EXEC_R;
               OP_ITYPE:          nxt = S_EXEC_I;
               OP_BRANCH:         nxt = S_BRANCH;
               default:           nxt = S_ILLEGAL;
            endcase
         end
         S_MEMADR: nxt = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC_R: nxt = S_ALUWB;
         S_EXEC_I: nxt = S_ALUWB;
         default:  nxt = S_FETCH;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      iord       = 1'b0;
      mem_to_reg = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      ALUOp      = 2'b00;
      retire     = 1'b0;
      illegal    = 1'b0;
      if (!reset) begin
         case (cur)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            // oldPC + imm lands in ALUOut for a possible branch later
            S_DECODE: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b10;
            end
            S_MEMADR: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               retire     = 1'b1;
            end
            S_MEMWR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
               retire    = mem_ready;
            end
            S_EXEC_R: begin
               alu_src_a = 2'b01;
               ALUOp     = 2'b10;
            end
            S_EXEC_I: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
               ALUOp     = 2'b11;
            end
            S_ALUWB: begin
               reg_write = 1'b1;
               retire    = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a = 2'b01;
               ALUOp     = 2'b01;
               pc_src    = 1'b1;
               pc_write  = zero;
               retire    = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instruction streams checked against a per-instruction phase model.
module tb_multicycle_control;

   logic       clk, reset, zero, mem_ready;
   logic [6:0] opcode;
   logic       pc_write, ir_write, mem_read, mem_write, reg_write, iord, mem_to_reg, pc_src;
   logic [1:0] alu_src_a, alu_src_b, ALUOp;
   logic       retire, illegal;
   logic [3:0] state;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct packed {
      logic pc_write, ir_write, mem_read, mem_write, reg_write, iord, mem_to_reg, pc_src;
      logic [1:0] a, b, op;
      logic retire, illegal;
   } ctl_t;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .iord(iord), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(ALUOp),
      .retire(retire), .illegal(illegal), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control vector expected for a given phase, straight from the per-state output table.
   function automatic ctl_t expect_ctl(input int st, input bit mr, input bit z, input bit rst);
      ctl_t c;
      c = '0;
      if (rst) return c;
      case (st)
         0:  begin c.mem_read = 1; c.b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
         1:  begin c.a = 2'b10; c.b = 2'b10; end
         2:  begin c.a = 2'b01; c.b = 2'b10; end
         3:  begin c.mem_read = 1; c.iord = 1; end
         4:  begin c.reg_write = 1; c.mem_to_reg = 1; c.retire = 1; end
         5:  begin c.mem_write = 1; c.iord = 1; c.retire = mr; end
         6:  begin c.a = 2'b01; c.op = 2'b10; end
         7:  begin c.a = 2'b01; c.b = 2'b10; c.op = 2'b11; end
         8:  begin c.reg_write = 1; c.retire = 1; end
         9:  begin c.a = 2'b01; c.op = 2'b01; c.pc_src = 1; c.pc_write = z; c.retire = 1; end
         10: c.illegal = 1;
         default: ;
      endcase
      return c;
   endfunction

   function automatic ctl_t observed();
      ctl_t c;
      c = {pc_write, ir_write, mem_read, mem_write, reg_write, iord, mem_to_reg, pc_src,
           alu_src_a, alu_src_b, ALUOp, retire, illegal};
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at posedge+1, sample at negedge, then advance.
   task automatic step(input int exp_st, input bit mr, input bit z, input logic [6:0] op,
                       input bit rst);
      reset = rst; mem_ready = mr; zero = z; opcode = op;
      @(negedge clk);
      chk($sformatf("state(exp %0d)", exp_st), {28'd0, state}, exp_st);
      chk($sformatf("ctl(st %0d)", exp_st), {15'd0, observed()}, {15'd0, expect_ctl(exp_st, mr, z, rst)});
      chk("exclusive", {30'd0, mem_read & mem_write, pc_write & reg_write}, 32'd0);
      @(posedge clk); #1;
   endtask

   // Phase list of one instruction: fw FETCH stalls, mw memory stalls.
   // zmode 0/1 fixes zero, 2 randomises it. abort_at injects reset at that phase index.
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input int zmode,
                            input int abort_at, output int n_retire, output int n_cyc);
      int sq[$];
      bit mq[$];
      bit z;
      logic [6:0] drv;
      for (int i = 0; i < fw; i++) begin sq.push_back(0); mq.push_back(0); end
      sq.push_back(0); mq.push_back(1);
      sq.push_back(1); mq.push_back(1'($urandom));
      case (op)
         7'b0000011: begin
            sq.push_back(2); mq.push_back(1'($urandom));
            for (int i = 0; i < mw; i++) begin sq.push_back(3); mq.push_back(0); end
            sq.push_back(3); mq.push_back(1);
            sq.push_back(4); mq.push_back(1'($urandom));
         end
         7'b0100011: begin
            sq.push_back(2); mq.push_back(1'($urandom));
            for (int i = 0; i < mw; i++) begin sq.push_back(5); mq.push_back(0); end
            sq.push_back(5); mq.push_back(1);
         end
         7'b0110011: begin sq.push_back(6); sq.push_back(8); mq.push_back(1'($urandom)); mq.push_back(1'($urandom)); end
         7'b0010011: begin sq.push_back(7); sq.push_back(8); mq.push_back(1'($urandom)); mq.push_back(1'($urandom)); end
         7'b1100011: begin sq.push_back(9); mq.push_back(1'($urandom)); end
         default:    begin sq.push_back(10); mq.push_back(1'($urandom)); end
      endcase
      n_retire = 0;
      n_cyc = 0;
      for (int i = 0; i < sq.size(); i++) begin
         z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
         drv = (sq[i] == 0) ? 7'($urandom) : op;
         if (i == abort_at) begin
            step(sq[i], 1'b0, z, drv, 1'b1);
            reset = 1'b0;
            return;
         end
         step(sq[i], mq[i], z, drv, 1'b0);
         n_cyc++;
         if (expect_ctl(sq[i], mq[i], z, 1'b0).retire) n_retire++;
      end
   endtask

   int nr, nc;
   logic [6:0] ops [5] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
   logic [6:0] rop;
   int fw, mw;

   initial begin
      reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 7'd0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         mem_ready = 1'($urandom);
         @(negedge clk);
         chk("reset_ctl", {15'd0, observed()}, 32'd0);
         @(posedge clk); #1;
         chk("reset_state", {28'd0, state}, 32'd0);
      end

      // R-type, no stalls: 0,1,6,8 then back to FETCH; latency 4.
      run_instr(7'b0110011, 0, 0, 2, -1, nr, nc);
      chk("rtype_lat", nc, 4);
      chk("rtype_retire", nr, 1);
      // Load with two MEMRD stalls: latency 5+2.
      run_instr(7'b0000011, 0, 2, 2, -1, nr, nc);
      chk("load_lat", nc, 7);
      // Branch taken, then not taken.
      run_instr(7'b1100011, 0, 0, 1, -1, nr, nc);
      chk("br_taken_lat", nc, 3);
      run_instr(7'b1100011, 0, 0, 0, -1, nr, nc);
      chk("br_nt_retire", nr, 1);
      // Illegal opcode.
      run_instr(7'b1111111, 0, 0, 2, -1, nr, nc);
      chk("illegal_retire", nr, 0);
      // FETCH stalled three cycles before an I-type.
      run_instr(7'b0010011, 3, 0, 2, -1, nr, nc);
      chk("itype_lat", nc, 7);
      // Store with reset on the second MEMWR wait cycle (phase index 4).
      run_instr(7'b0100011, 0, 3, 2, 4, nr, nc);
      chk("store_abort_retire", nr, 0);
      // Reset in the middle of a MEMRD wait.
      run_instr(7'b0000011, 1, 4, 2, 5, nr, nc);

      for (int k = 0; k < 60; k++) begin
         rop = ($urandom_range(0, 5) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
         fw = $urandom_range(0, 2);
         mw = $urandom_range(0, 3);
         run_instr(rop, fw, mw, 2, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1, nr, nc);
      end
      // Final instruction confirms FETCH is reached after the random stream.
      run_instr(7'b0110011, 0, 0, 2, -1, nr, nc);
      chk("final_retire", nr, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
